// File: rtl/psum_accumulator_pkg.sv
// Shared types and saturation-bound helpers for the partial-sum accumulator.
package psum_accumulator_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;

   // Largest / smallest value representable in a w-bit signed word.
   function automatic longint sat_max(input int unsigned w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int unsigned w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/psum_fifo.sv
// First-word-fall-through buffer for requantized group results.
module psum_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     arst_in,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic                     valid_o,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_c, pop_en_c, push_en_c;

   assign valid_o   = (count_q != '0);
   assign full_c    = (count_q == CW'(DEPTH));
   assign pop_en_c  = pop_i && valid_o;
   // A push into a full buffer is only allowed when the head leaves the same cycle.
   assign push_en_c = push_i && (!full_c || pop_en_c);
   assign data_o    = valid_o ? mem_q[rd_q] : '0;
   assign count_o   = count_q;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push_en_c) wr_d = wr_q + AW'(1);
      if (pop_en_c)  rd_d = rd_q + AW'(1);
      case ({push_en_c, pop_en_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en_c) mem_q[wr_q] <= push_data_i;
   end

endmodule

// File: rtl/psum_accumulator.sv
// Groups signed MAC partial sums, requantizes each group result and buffers it.
// Optional clamp on output narrowing: define PSUM_SATURATION_EN.
module psum_accumulator
   import psum_accumulator_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = 34,
   parameter int unsigned ACC_WIDTH  = 42,
   parameter int unsigned OUT_WIDTH  = 16,
   parameter int unsigned OUT_SHIFT  = 0,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  arst_in,
   input  logic [CNT_WIDTH-1:0]  cfg_len,
   input  logic                  in_valid,
   input  logic [IN_WIDTH-1:0]   in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [OUT_WIDTH-1:0]  out_data,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   state_e                       state_q, state_d;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic signed [ACC_WIDTH-1:0]  in_ext_c, sum_c, shifted_c;
   logic [CNT_WIDTH-1:0]         cnt_q, cnt_d, len_q, len_d, len_eff_c;
   logic                         pend_q, pend_d;
   logic [OUT_WIDTH-1:0]         pdata_q, pdata_d, narrow_c;
   logic [CW-1:0]                fifo_count;
   logic                         accept_c, finish_c;

   assign in_ext_c  = ACC_WIDTH'($signed(in_data));
   assign len_eff_c = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
   assign sum_c     = (state_q == ACCUM) ? acc_q + in_ext_c : in_ext_c;
   assign shifted_c = sum_c >>> OUT_SHIFT;

   // Credit check uses only registered occupancy so a same-cycle pop cannot raise it.
   assign in_ready  = (fifo_count + CW'(pend_q)) < CW'(FIFO_DEPTH);
   assign accept_c  = in_valid && in_ready;
   assign finish_c  = accept_c && ((state_q == IDLE) ? (len_eff_c == CNT_WIDTH'(1))
                                                     : (cnt_q == len_q - CNT_WIDTH'(1)));
   assign busy      = (state_q == ACCUM) || pend_q;

`ifdef PSUM_SATURATION_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_max(OUT_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_min(OUT_WIDTH));

   always_comb begin
      narrow_c = OUT_WIDTH'(shifted_c);
      if (shifted_c > SAT_HI)      narrow_c = OUT_WIDTH'(SAT_HI);
      else if (shifted_c < SAT_LO) narrow_c = OUT_WIDTH'(SAT_LO);
   end
`else
   assign narrow_c = OUT_WIDTH'(shifted_c);
`endif

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c && !finish_c) state_d = ACCUM;
         ACCUM:   if (finish_c)              state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      pend_d  = finish_c;
      pdata_d = finish_c ? narrow_c : pdata_q;
      if (accept_c && !finish_c) begin
         if (state_q == IDLE) begin
            len_d = len_eff_c;
            acc_d = in_ext_c;
            cnt_d = CNT_WIDTH'(1);
         end else begin
            acc_d = sum_c;
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         pend_q  <= 1'b0;
         pdata_q <= '0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         pend_q  <= pend_d;
         pdata_q <= pdata_d;
      end
   end

   psum_fifo #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .arst_in     (arst_in),
      .push_i      (pend_q),
      .push_data_i (pdata_q),
      .pop_i       (out_ready),
      .valid_o     (out_valid),
      .data_o      (out_data),
      .count_o     (fifo_count)
   );

endmodule
